// File: rtl/fp16g_to_fp32_pipe_if.sv
// Stream bundle for the FP16-Green -> FP32 converter: FP16-Green operand in, FP32 result plus class flags out.
// slave is the converter's view; master is the producer/consumer side that drives it.
interface fp16g_to_fp32_pipe_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_is_zero;
    logic        out_is_inf;
    logic        out_is_nan;
    logic        out_was_sub;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data,
        output out_is_zero, out_is_inf, out_is_nan, out_was_sub
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data,
        input  out_is_zero, out_is_inf, out_is_nan, out_was_sub
    );
endinterface

// File: rtl/fp16g_to_fp32_pipe.sv
// Two-stage lossless FP16-Green (s1/e6/m9, bias 31) -> FP32 widening converter with valid/ready flow control.
// Define FP16G2FP32_DAZ_EN to flush subnormal inputs to signed zero (no leading-one detector or shifter).
module fp16g_to_fp32_pipe (
    input  logic                clk,
    input  logic                rst_n,
    fp16g_to_fp32_pipe_if.slave bus
);
    localparam int         STAGES       = 2;
    localparam logic [5:0] EXP16_MAX    = 6'h3F;
    localparam logic [7:0] NORM_EXP_ADJ = 8'd96;   // 127 - 31
    localparam logic [7:0] EXP32_MAX    = 8'hFF;
    localparam logic [22:0] QNAN_BIT    = 23'h400000;
`ifndef FP16G2FP32_DAZ_EN
    // man * 2^-39 normalized: leading one at bit p gives 2^(p-39), biased p + 88
    localparam logic [7:0] SUB_EXP_ADJ  = 8'd88;
`endif

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_SUB,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } cls_e;

    typedef struct packed {
        logic       sign;
        cls_e       cls;
        logic [5:0] exp;
        logic [8:0] man;
`ifndef FP16G2FP32_DAZ_EN
        logic [3:0] lz_pos;
`endif
    } s1_t;

    typedef struct packed {
        logic [31:0] data;
        logic        is_zero;
        logic        is_inf;
        logic        is_nan;
        logic        was_sub;
    } s2_t;

    logic [STAGES:1] vld_pipe;
    logic            s1_adv;
    logic            s2_adv;
    s1_t             s1_d;
    s1_t             s1_q;
    s2_t             s2_d;
    s2_t             s2_q;

    // Stage 2 advances whenever its slot is empty or being drained; stage 1 follows.
    assign s2_adv      = !vld_pipe[2] || bus.out_ready;
    assign s1_adv      = !vld_pipe[1] || s2_adv;
    assign bus.in_ready = s1_adv;

    always_comb begin
        s1_d      = '0;
        s1_d.sign = bus.in_data[15];
        s1_d.exp  = bus.in_data[14:9];
        s1_d.man  = bus.in_data[8:0];
        if (s1_d.exp == 6'd0)
            s1_d.cls = (s1_d.man == 9'd0) ? CLS_ZERO : CLS_SUB;
        else if (s1_d.exp == EXP16_MAX)
            s1_d.cls = (s1_d.man == 9'd0) ? CLS_INF : CLS_NAN;
        else
            s1_d.cls = CLS_NORM;
`ifndef FP16G2FP32_DAZ_EN
        // Ascending scan: the highest set bit is the last one written
        for (int i = 0; i < 9; i++)
            if (s1_d.man[i]) s1_d.lz_pos = 4'(i);
`endif
    end

`ifndef FP16G2FP32_DAZ_EN
    logic [4:0]  sub_sh;
    logic [22:0] sub_man;
    // Shifting the leading one to bit 23 drops it off the 23-bit field, leaving the fraction below it
    assign sub_sh  = 5'd23 - {1'b0, s1_q.lz_pos};
    assign sub_man = {14'b0, s1_q.man} << sub_sh;
`endif

    always_comb begin
        s2_d = '0;
        case (s1_q.cls)
            CLS_ZERO: begin
                s2_d.data    = {s1_q.sign, 31'b0};
                s2_d.is_zero = 1'b1;
            end
            CLS_SUB: begin
`ifdef FP16G2FP32_DAZ_EN
                s2_d.data    = {s1_q.sign, 31'b0};
                s2_d.is_zero = 1'b1;
`else
                s2_d.data    = {s1_q.sign, {4'b0, s1_q.lz_pos} + SUB_EXP_ADJ, sub_man};
`endif
                s2_d.was_sub = 1'b1;
            end
            CLS_NORM: begin
                s2_d.data = {s1_q.sign, {2'b0, s1_q.exp} + NORM_EXP_ADJ, s1_q.man, 14'b0};
            end
            CLS_INF: begin
                s2_d.data   = {s1_q.sign, EXP32_MAX, 23'b0};
                s2_d.is_inf = 1'b1;
            end
            CLS_NAN: begin
                s2_d.data   = {s1_q.sign, EXP32_MAX, {s1_q.man, 14'b0} | QNAN_BIT};
                s2_d.is_nan = 1'b1;
            end
            default: s2_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
        end else begin
            if (s1_adv) vld_pipe[1] <= bus.in_valid;
            if (s2_adv) vld_pipe[2] <= vld_pipe[1];
            if (s1_adv && bus.in_valid) s1_q <= s1_d;
            if (s2_adv && vld_pipe[1])  s2_q <= s2_d;
        end
    end

    assign bus.out_valid   = vld_pipe[2];
    assign bus.out_data    = s2_q.data;
    assign bus.out_is_zero = s2_q.is_zero;
    assign bus.out_is_inf  = s2_q.is_inf;
    assign bus.out_is_nan  = s2_q.is_nan;
    assign bus.out_was_sub = s2_q.was_sub;
endmodule

// File: tb/tb_fp16g_to_fp32_pipe.sv
// Directed-vector bench for fp16g_to_fp32_pipe: conversions, backpressure, mid-stream reset, random stream.
// Result words are {is_zero, is_inf, is_nan, was_sub, data[31:0]}.
module tb_fp16g_to_fp32_pipe;
    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    fp16g_to_fp32_pipe_if bus ();

    fp16g_to_fp32_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef FP16G2FP32_DAZ_EN
    localparam logic [35:0] E_0001 = {4'b1001, 32'h00000000};
    localparam logic [35:0] E_01FF = {4'b1001, 32'h00000000};
    localparam logic [35:0] E_8001 = {4'b1001, 32'h80000000};
`else
    localparam logic [35:0] E_0001 = {4'b0001, 32'h2C000000};
    localparam logic [35:0] E_01FF = {4'b0001, 32'h307F8000};
    localparam logic [35:0] E_8001 = {4'b0001, 32'hAC000000};
`endif

    function automatic logic [35:0] res();
        return {bus.out_is_zero, bus.out_is_inf, bus.out_is_nan, bus.out_was_sub, bus.out_data};
    endfunction

    // Reference: subnormals normalized by repeated doubling rather than a priority encoder
    function automatic logic [35:0] model(input logic [15:0] d);
        logic       s;
        logic [5:0] e;
        logic [8:0] m;
        logic [9:0] mm;
        int         ex;
        s = d[15];
        e = d[14:9];
        m = d[8:0];
        if (e == 6'd0 && m == 9'd0) return {4'b1000, s, 31'b0};
        if (e == 6'd0) begin
`ifdef FP16G2FP32_DAZ_EN
            return {4'b1001, s, 31'b0};
`else
            mm = {1'b0, m};
            ex = 97;
            while (!mm[9]) begin
                mm = mm << 1;
                ex = ex - 1;
            end
            return {4'b0001, s, ex[7:0], mm[8:0], 14'b0};
`endif
        end
        if (e == 6'h3F && m == 9'd0) return {4'b0100, s, 8'hFF, 23'b0};
        if (e == 6'h3F) return {4'b0010, s, 8'hFF, 1'b1, m[7:0], 14'b0};
        ex = int'(e) + 96;
        return {4'b0000, s, ex[7:0], m, 14'b0};
    endfunction

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expects an empty pipeline; checks the two-edge latency and the converted word
    task automatic conv(input string tag, input logic [15:0] d, input logic [35:0] exp);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk({tag, "_lat1"}, {35'b0, bus.out_valid}, 36'd0);
        @(posedge clk); #1;
        chk({tag, "_vld"}, {35'b0, bus.out_valid}, 36'd1);
        chk(tag, res(), exp);
        @(posedge clk); #1;
    endtask

    logic [35:0] sb[$];

    initial begin
        int sent;
        int got;
        int cyc;
        int n_rnd;
        compared      = 0;
        mismatched    = 0;
        clk           = 1'b0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0;
        bus.out_ready = 1'b0;

        #3;
        chk("rst_out", {bus.out_valid, 3'b0, res()} , 40'h0);
        chk("rst_in_ready", {35'b0, bus.in_ready}, 36'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        conv("n_3E00", 16'h3E00, {4'b0000, 32'h3F800000});
        conv("n_C080", 16'hC080, {4'b0000, 32'hC0200000});
        conv("n_7DFF", 16'h7DFF, {4'b0000, 32'h4F7FC000});
        conv("n_0200", 16'h0200, {4'b0000, 32'h30800000});
        conv("s_0001", 16'h0001, E_0001);
        conv("s_01FF", 16'h01FF, E_01FF);
        conv("s_8001", 16'h8001, E_8001);
        conv("z_0000", 16'h0000, {4'b1000, 32'h00000000});
        conv("z_8000", 16'h8000, {4'b1000, 32'h80000000});
        conv("i_7E00", 16'h7E00, {4'b0100, 32'h7F800000});
        conv("i_FE00", 16'hFE00, {4'b0100, 32'hFF800000});
        conv("q_7E01", 16'h7E01, {4'b0010, 32'h7FC04000});
        conv("q_7FFF", 16'h7FFF, {4'b0010, 32'h7FFFC000});

        // Backpressure: two accepts fill the pipe, third input waits for out_ready
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h3E00;
        @(posedge clk); #1;
        bus.in_data = 16'h4000;
        chk("bp_ready2", {35'b0, bus.in_ready}, 36'd1);
        @(posedge clk); #1;
        bus.in_data = 16'hC080;
        chk("bp_ready3", {35'b0, bus.in_ready}, 36'd0);
        chk("bp_hold0", res(), {4'b0000, 32'h3F800000});
        repeat (3) @(posedge clk);
        #1;
        chk("bp_stall_ready", {35'b0, bus.in_ready}, 36'd0);
        chk("bp_hold1", {bus.out_valid, 3'b0, res()}, {4'b1000, 4'b0000, 32'h3F800000});
        bus.out_ready = 1'b1;
        #1;
        chk("bp_accept3", {35'b0, bus.in_ready}, 36'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("bp_out2", {bus.out_valid, 3'b0, res()}, {4'b1000, 4'b0000, 32'h40000000});
        @(posedge clk); #1;
        chk("bp_out3", {bus.out_valid, 3'b0, res()}, {4'b1000, 4'b0000, 32'hC0200000});
        @(posedge clk); #1;
        chk("bp_empty", {35'b0, bus.out_valid}, 36'd0);

        // Reset with both stages full
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h3E00;
        @(posedge clk); #1;
        bus.in_data = 16'h4000;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("mr_full", {35'b0, bus.out_valid}, 36'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_out", {bus.out_valid, 3'b0, res()}, 40'h0);
        chk("mr_in_ready", {35'b0, bus.in_ready}, 36'd1);
        @(posedge clk); #1;
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("mr_no_stale", {35'b0, bus.out_valid}, 36'd0);
        end
        conv("mr_new", 16'hC080, {4'b0000, 32'hC0200000});

        // Random valid/ready stream against the reference model
        n_rnd = 2000;
        sent  = 0;
        got   = 0;
        cyc   = 0;
        while (got < n_rnd && cyc < 20000) begin
            bus.in_valid  = (sent < n_rnd) && ($urandom_range(0, 3) != 0);
            bus.in_data   = 16'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(model(bus.in_data));
                sent++;
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("rnd_expected", {35'b0, sb.size() != 0}, 36'd1);
                if (sb.size() != 0) chk("rnd_data", res(), sb.pop_front());
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_valid = 1'b0;
        chk("rnd_count", 36'(got), 36'(n_rnd));
        chk("rnd_leftover", 36'(sb.size()), 36'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
